// File: rtl/cpe_sum_buffer.sv
// FWFT buffer for decoded sums with per-word error flags and optional statistics.
// Define CPE_BUF_STATS_EN to build the err_count/overflow statistics logic.
module cpe_sum_buffer #(
   parameter int unsigned NBIT  = 7,
   parameter int unsigned NCODE = 15,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NCODE-1:0]         ccw,
   input  logic                     ccw_valid,
   input  logic                     err_in,
   output logic                     in_ready,
   output logic [NBIT-1:0]          dec_sum,
   output logic                     err_out,
   output logic                     out_valid,
   input  logic                     out_ready,
   input  logic                     clr_stats,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         err_count,
   output logic                     overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam logic [LW-1:0] FullLvl = LW'(DEPTH);

   logic [LW-1:0] wr_ptr_q, wr_ptr_d;
   logic [LW-1:0] rd_ptr_q, rd_ptr_d;
   logic [NBIT:0] mem_q [DEPTH];
   logic [NBIT:0] mem_d [DEPTH];
   logic [NBIT:0] hold_q, hold_d;
   logic [NBIT:0] head;
   logic          push;
   logic          pop;

   // Only the systematic low bits carry the decoded sum.
   logic unused_ccw_hi;
   assign unused_ccw_hi = ^ccw[NCODE-1:NBIT];

   assign level     = wr_ptr_q - rd_ptr_q;
   assign in_ready  = (level != FullLvl);
   assign out_valid = (level != '0);
   assign push      = ccw_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // An empty buffer shows the last word that left it (zero after reset).
   assign head              = out_valid ? mem_q[rd_ptr_q[AW-1:0]] : hold_q;
   assign {err_out, dec_sum} = head;

   always_comb begin
      wr_ptr_d = wr_ptr_q + LW'(push);
      rd_ptr_d = rd_ptr_q + LW'(pop);
      hold_d   = pop ? head : hold_q;
      mem_d    = mem_q;
      if (push) begin
         mem_d[wr_ptr_q[AW-1:0]] = {err_in, ccw[NBIT-1:0]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         hold_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         hold_q   <= hold_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

`ifdef CPE_BUF_STATS_EN
   logic [CNT_W-1:0] err_count_q, err_count_d;
   logic             overflow_q, overflow_d;

   always_comb begin
      err_count_d = err_count_q;
      overflow_d  = overflow_q;
      if (clr_stats) begin
         err_count_d = '0;
         overflow_d  = 1'b0;
      end else begin
         if (push && err_in && (err_count_q != '1)) begin
            err_count_d = err_count_q + CNT_W'(1);
         end
         if (ccw_valid && !in_ready) begin
            overflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         err_count_q <= err_count_d;
         overflow_q  <= overflow_d;
      end
   end

   assign err_count = err_count_q;
   assign overflow  = overflow_q;
`else
   logic unused_clr_stats;
   assign unused_clr_stats = clr_stats;
   assign err_count        = '0;
   assign overflow         = 1'b0;
`endif

endmodule

// File: tb/tb_cpe_sum_buffer.sv
// Self-checking bench for cpe_sum_buffer: vector table plus scoreboard-driven sequences.
// Statistics expectations follow CPE_BUF_STATS_EN as seen by this bench.
module tb_cpe_sum_buffer;

`ifdef CPE_BUF_STATS_EN
   localparam bit StatsEn = 1'b1;
`else
   localparam bit StatsEn = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [14:0] ccw;
   logic        ccw_valid;
   logic        err_in;
   logic        in_ready;
   logic [6:0]  dec_sum;
   logic        err_out;
   logic        out_valid;
   logic        out_ready;
   logic        clr_stats;
   logic [3:0]  level;
   logic [7:0]  err_count;
   logic        overflow;

   cpe_sum_buffer dut (
      .clk       (clk),
      .rst       (rst),
      .ccw       (ccw),
      .ccw_valid (ccw_valid),
      .err_in    (err_in),
      .in_ready  (in_ready),
      .dec_sum   (dec_sum),
      .err_out   (err_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .clr_stats (clr_stats),
      .level     (level),
      .err_count (err_count),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] sb[$];
   logic [7:0] m_hold;
   int         m_err;
   logic       m_ovf;

   typedef struct {
      logic        v;
      logic [14:0] cw;
      logic        e;
      logic        r;
      logic [3:0]  lvl;
      logic [6:0]  dec;
      logic        er;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_level"}, 32'(level), 0);
      chk({tag, "_out_valid"}, 32'(out_valid), 0);
      chk({tag, "_in_ready"}, 32'(in_ready), 1);
      chk({tag, "_dec_sum"}, 32'(dec_sum), 0);
      chk({tag, "_err_out"}, 32'(err_out), 0);
      chk({tag, "_err_count"}, 32'(err_count), 0);
      chk({tag, "_overflow"}, 32'(overflow), 0);
   endtask

   // One clock: drive inputs, check against the model mid-cycle, then advance the model.
   task automatic cycle(input logic v, input logic [14:0] cw, input logic e, input logic r,
                        input logic c);
      logic       do_push;
      logic       do_pop;
      logic [7:0] exp;
      ccw_valid = v;
      ccw       = cw;
      err_in    = e;
      out_ready = r;
      clr_stats = c;
      @(negedge clk);
      chk("level", 32'(level), 32'(sb.size()));
      chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(sb.size() != 8));
      do_push = v && (sb.size() != 8);
      do_pop  = r && (sb.size() != 0);
      if (do_pop) begin
         exp = sb.pop_front();
         chk("pop_data", 32'({err_out, dec_sum}), 32'(exp));
         m_hold = exp;
      end else if (sb.size() != 0) begin
         chk("head", 32'({err_out, dec_sum}), 32'(sb[0]));
      end else begin
         chk("hold", 32'({err_out, dec_sum}), 32'(m_hold));
      end
      chk("err_count", 32'(err_count), StatsEn ? 32'(m_err) : 32'd0);
      chk("overflow", 32'(overflow), StatsEn ? 32'(m_ovf) : 32'd0);
      if (c) begin
         m_err = 0;
         m_ovf = 1'b0;
      end else begin
         if (do_push && e && m_err < 255) m_err++;
         if (v && !do_push) m_ovf = 1'b1;
      end
      if (do_push) sb.push_back({e, cw[6:0]});
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0] = '{1'b1, 15'h0055, 1'b0, 1'b0, 4'd1, 7'h55, 1'b0};
      vecs[1] = '{1'b1, 15'h7F01, 1'b1, 1'b0, 4'd2, 7'h55, 1'b0};
      vecs[2] = '{1'b1, 15'h0002, 1'b0, 1'b0, 4'd3, 7'h55, 1'b0};
      vecs[3] = '{1'b1, 15'h0003, 1'b0, 1'b1, 4'd3, 7'h01, 1'b1};
      vecs[4] = '{1'b0, 15'h0000, 1'b0, 1'b1, 4'd2, 7'h02, 1'b0};
      vecs[5] = '{1'b0, 15'h0000, 1'b0, 1'b1, 4'd1, 7'h03, 1'b0};
      vecs[6] = '{1'b0, 15'h0000, 1'b0, 1'b1, 4'd0, 7'h03, 1'b0};

      m_hold    = '0;
      m_err     = 0;
      m_ovf     = 1'b0;
      rst       = 1'b1;
      ccw       = '0;
      ccw_valid = 1'b0;
      err_in    = 1'b0;
      out_ready = 1'b0;
      clr_stats = 1'b0;
      #1;
      chk_reset("por");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // First word latency, upper-bit discard, push+pop at level 3.
      for (int i = 0; i < 7; i++) begin
         cycle(vecs[i].v, vecs[i].cw, vecs[i].e, vecs[i].r, 1'b0);
         chk("vec_level", 32'(level), 32'(vecs[i].lvl));
         chk("vec_out_valid", 32'(out_valid), 32'(vecs[i].lvl != 0));
         chk("vec_dec_sum", 32'(dec_sum), 32'(vecs[i].dec));
         chk("vec_err_out", 32'(err_out), 32'(vecs[i].er));
      end

      // Fill to full, overflow on drop (also with out_ready high), then drain in order.
      for (int k = 1; k <= 8; k++) cycle(1'b1, 15'h4000 | 15'(k), k[0], 1'b0, 1'b0);
      chk("full_level", 32'(level), 8);
      chk("full_in_ready", 32'(in_ready), 0);
      cycle(1'b1, 15'h0009, 1'b1, 1'b0, 1'b0);
      chk("ovf_set", 32'(overflow), StatsEn ? 32'd1 : 32'd0);
      chk("ovf_err_count", 32'(err_count), StatsEn ? 32'd5 : 32'd0);
      cycle(1'b1, 15'h000A, 1'b1, 1'b1, 1'b0);
      chk("full_pop_level", 32'(level), 7);
      for (int k = 0; k < 16 && sb.size() != 0; k++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      chk("drained", 32'(sb.size()), 0);

      // Clear statistics without touching the data path.
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("clr_overflow", 32'(overflow), 0);

      // Saturation of err_count, then clear coincident with a flagged push.
      for (int k = 0; k < 300; k++) cycle(1'b1, 15'(k), 1'b1, 1'b1, 1'b0);
      chk("sat_err_count", 32'(err_count), StatsEn ? 32'd255 : 32'd0);
      cycle(1'b1, 15'h0011, 1'b1, 1'b1, 1'b1);
      chk("clr_wins", 32'(err_count), 0);
      for (int k = 0; k < 16 && sb.size() != 0; k++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

      // Asynchronous reset mid-operation at level 5.
      for (int k = 0; k < 5; k++) cycle(1'b1, 15'h0020 + 15'(k), 1'b1, 1'b0, 1'b0);
      chk("pre_rst_level", 32'(level), 5);
      #2;
      rst = 1'b1;
      #1;
      chk_reset("async");
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      m_hold = '0;
      m_err  = 0;
      m_ovf  = 1'b0;
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 15'h0033, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cpe_sum_buffer.md
CPE_SUM_BUFFER -- requirements
Module: cpe_sum_buffer

Interface
REQ-001 The block SHALL have parameter NBIT, default 7, data bits per decoded sum.
REQ-002 The block SHALL have parameter NCODE, default 15, codeword width.
REQ-003 The block SHALL have parameter DEPTH, default 8, FIFO entries; must be a power of two, at least 2.
REQ-004 The block SHALL have parameter CNT_W, default 8, error-counter width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port ccw, input, NCODE bits: corrected codeword from the corrector.
REQ-008 The block SHALL have port ccw_valid, input, 1 bit: the corrector's ready strobe; ccw is valid this cycle.
REQ-009 The block SHALL have port err_in, input, 1 bit: detector error flag belonging to this ccw.
REQ-010 The block SHALL have port in_ready, output, 1 bit: buffer can accept a word.
REQ-011 The block SHALL have port dec_sum, output, NBIT bits: head-of-FIFO decoded sum.
REQ-012 The block SHALL have port err_out, output, 1 bit: error flag stored with the head word.
REQ-013 The block SHALL have port out_valid, output, 1 bit: head word present.
REQ-014 The block SHALL have port out_ready, input, 1 bit: consumer accepts the head word.
REQ-015 The block SHALL have port clr_stats, input, 1 bit: synchronous clear of the statistics.
REQ-016 The block SHALL have port level, output, log2(DEPTH)+1 bits: current occupancy.
REQ-017 The block SHALL have port err_count, output, CNT_W bits: count of accepted words flagged erroneous.
REQ-018 The block SHALL have port overflow, output, 1 bit: sticky flag, a word was dropped.

Function
REQ-019 Stored data SHALL be {err_in, ccw[NBIT-1:0]}; the systematic low bits are the decoded sum, and upper codeword bits are discarded.
REQ-020 Push SHALL occur when ccw_valid and in_ready are both high; in_ready SHALL equal (level != DEPTH).
REQ-021 Pop SHALL occur when out_valid and out_ready are both high; out_valid SHALL equal (level != 0).
REQ-022 Reads SHALL be first-word-fall-through: dec_sum and err_out are combinationally driven from the head entry; with no valid head they hold the last head value.
REQ-023 Write-to-read latency SHALL be 1 cycle: a word pushed into an empty buffer asserts out_valid on the next cycle.
REQ-024 A simultaneous push and pop with 0 < level < DEPTH SHALL leave level unchanged and preserve order.
REQ-025 When full, a pop frees a slot only from the next cycle; in_ready does not depend on out_ready.
REQ-026 When ccw_valid is high and the buffer is full, the word SHALL be dropped, overflow SHALL set, and err_count SHALL be unaffected.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; level SHALL be the pointer difference with an extra wrap bit.
REQ-028 err_count SHALL increment on each push with err_in=1 and saturate at 2^CNT_W-1.
REQ-029 When clr_stats is high, err_count and overflow SHALL clear next edge; clear wins over a same-cycle increment or overflow set; FIFO contents are untouched.

Reset
REQ-030 While rst is high, the block SHALL immediately force pointers and level to 0, out_valid to 0, in_ready to 1, err_count to 0, overflow to 0, and dec_sum/err_out to 0.
REQ-031 Reset asserted mid-operation SHALL discard all stored words; no pop is reported afterward.
REQ-032 Storage array contents SHALL NOT need resetting.

Configuration
REQ-033 Macro CPE_BUF_STATS_EN SHALL control the statistics logic: defined implements err_count and overflow per REQ-026, REQ-028 and REQ-029; undefined ties both outputs to 0, removes their registers, and ignores clr_stats, while dropping on full still applies.

Verification
REQ-034 The bench SHALL cover this scenario: after reset, push ccw=15'h0055 with err_in=0 -> next cycle out_valid=1, dec_sum=7'h55, err_out=0, level=1.
REQ-035 The bench SHALL cover this scenario: push 8 words 1..8 with out_ready=0 -> level=8, in_ready=0; a 9th push sets overflow=1; draining yields 1..8 in order.
REQ-036 The bench SHALL cover this scenario: at level=3, push and pop in the same cycle -> level stays 3, head advances, and the new word appears last.
REQ-037 The bench SHALL cover this scenario: with CNT_W=8, 300 pushes with err_in=1 -> err_count=255; clr_stats coincident with a flagged push -> err_count=0.
REQ-038 The bench SHALL cover this scenario: rst pulsed asynchronously at level=5 -> immediately level=0, out_valid=0, in_ready=1.
REQ-039 The bench SHALL cover this scenario: with CPE_BUF_STATS_EN undefined, repeat REQ-035 -> overflow stays 0 and err_count stays 0, and the data path is unchanged.
